// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative RV32M multiply/divide sequencer (shift-add multiply,
// restoring divide, one iteration per cycle, with divide fast paths and flush).
module muldiv_seq_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  // encoding chosen so busy_o/done_o are direct state register bits
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [W-1:0]  r_hi, r_lo, r_b, r_result;
  logic          r_neg, r_neg_r;
  logic          w_is_div, w_sa, w_sb, w_neg_a, w_neg_b, w_bz, w_ovf, w_fast, w_accept, w_last;
  logic [W-1:0]  w_mag_a, w_mag_b, w_fast_res, w_hi_n, w_lo_n, w_quo, w_rem, w_final;
  logic [W:0]    w_add, w_shift, w_diff;
  logic [2*W-1:0] w_prod, w_prod_s;
  assign w_is_div   = funct3_i[2];
  assign w_sa       = (funct3_i == 3'b001) | (funct3_i == 3'b010) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign w_sb       = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign w_neg_a    = w_sa & rs1_i[W-1];
  assign w_neg_b    = w_sb & rs2_i[W-1];
  assign w_mag_a    = w_neg_a ? -rs1_i : rs1_i;
  assign w_mag_b    = w_neg_b ? -rs2_i : rs2_i;
  assign w_bz       = rs2_i == '0;
  assign w_ovf      = ~funct3_i[0] & (rs1_i == {1'b1, {(W-1){1'b0}}}) & (&rs2_i);
  assign w_fast     = w_is_div & (w_bz | w_ovf);
  assign w_fast_res = w_bz ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
  assign w_accept   = start_i & ~flush_i & (r_state != BUSY);
  assign w_last     = r_cnt == CW'(W-1);
  // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  assign w_add      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift    = {r_hi, r_lo[W-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_hi_n     = r_op[2] ? (w_diff[W] ? {r_hi[W-2:0], r_lo[W-1]} : w_diff[W-1:0]) : w_add[W:1];
  assign w_lo_n     = r_op[2] ? {r_lo[W-2:0], ~w_diff[W]} : {w_add[0], r_lo[W-1:1]};
  assign w_prod     = {w_hi_n, w_lo_n};
  assign w_prod_s   = r_neg ? -w_prod : w_prod;
  assign w_quo      = r_neg ? -w_lo_n : w_lo_n;
  assign w_rem      = r_neg_r ? -w_hi_n : w_hi_n;
  assign w_final    = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                    : (r_op[1:0] == 2'b00 ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = IDLE;
    if (!flush_i)
      w_state_n = (r_state == BUSY) ? (w_last ? DONE : BUSY)
                : start_i ? (w_fast ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op    <= funct3_i;
      r_cnt   <= '0;
      r_neg   <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
      r_hi    <= '0;
      r_lo    <= w_is_div ? w_mag_a : w_mag_b;
      r_b     <= w_is_div ? w_mag_b : w_mag_a;
      if (w_fast) r_result <= w_fast_res;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CW'(1);
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      if (w_last) r_result <= w_final;
    end
  assign busy_o   = r_state[0];
  assign done_o   = r_state[1];
  assign result_o = r_result;
endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Iterative sequencer for the RV32M multiply/divide extension. It sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse and holds the pipeline via busy_o. Runs a shift-add or restoring-division loop for DATA_WIDTH cycles, then pulses done_o with the result.
- Handles signed/unsigned operand conditioning, the divide-by-zero and signed-overflow fast paths, and pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand/result width. The iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request; sampled only when state is IDLE or DONE
- funct3_i  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  in  DATA_WIDTH  operand A (multiplicand or dividend)
- rs2_i  in  DATA_WIDTH  operand B (multiplier or divisor)
- flush_i  in  1  abort any operation in progress
- busy_o  out  1  high while state is BUSY; the pipeline stalls on it
- done_o  out  1  one-cycle result-valid pulse
- result_o  out  DATA_WIDTH  result; held stable until the next accepted start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy_o=0, done_o=0, result_o=0, iteration counter=0, all internal operand/accumulator registers=0.
  - Reset asserted mid-operation discards the operation; done_o never pulses for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start_i=1 -> latch funct3, rs1, rs2. Go to DONE if a fast path applies, otherwise go to BUSY with counter=0.
  - BUSY: one iteration per cycle, counter increments. When counter reaches DATA_WIDTH-1, apply sign correction and result select in the same edge, write result_o, go to DONE.
  - DONE: done_o=1 for exactly this cycle. Next edge: start_i=1 is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
- start_i while BUSY is ignored; operands are not re-latched.
- Latency, with the accepting edge as E0:
  - Normal op: BUSY during cycles E0..E31, DONE (done_o=1) in the cycle after E32. busy_o is 1 for exactly 32 cycles.
  - Fast path: DONE in the cycle after E0; busy_o never rises.
- Fast paths (division ops only):
  - Divisor==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Arithmetic:
  - Signed ops run on magnitudes; the sign is applied at the end.
  - MUL returns the low word of the 2*DATA_WIDTH product. MULH/MULHSU/MULHU return the high word.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1). Truncation is toward zero.
- flush_i:
  - Any state -> IDLE on the next edge; busy_o and done_o are 0 from that edge onward; result_o is unchanged.
  - flush_i has priority over start_i in the same cycle, and also over BUSY completion in the same cycle.
- done_o and busy_o are never high simultaneously.
- All outputs come straight from registers; there is no combinational path from inputs to outputs.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> busy_o 32 cycles, then done_o pulse with result_o=0xFFFFFFEB. Then start MULHU 0xFFFFFFFF*0xFFFFFFFF in the DONE cycle -> accepted back-to-back, result_o=0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths:
  - DIVU 0x1234/0 -> done_o in the cycle after acceptance, result_o=0xFFFFFFFF, busy_o stays 0.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- Flush: start DIV, assert flush_i at BUSY cycle 10 -> IDLE next edge, busy_o=0, no done_o, result_o keeps its prior value. A flush and start in the same cycle -> no operation accepted.
- Reset: drop rst_n mid-BUSY -> outputs 0 immediately (asynchronous). Release, then run MUL 3*5 -> 15 with full 32-cycle latency.
